col2img8: RTL and testbench
===========================

# col2img8

Write-back stage of the convolution datapath. Accepts 8-lane byte results from the compute array in column-first order, one output column of 8 vertically adjacent pixels per beat, and transposes each 8x8 tile. It then emits row-major 64-bit words with addresses into the output feature-map buffer, which is the reverse of the 64-bit-to-lanes direction used on the input side. Ping-pong tile buffers let the fill and drain sides overlap.

## Interface
- OUT_W, 32, full-resolution output width in pixels; multiple of 16
- OUT_H, 16, full-resolution output height in pixels; multiple of 16
- ADDR_W, 16, memory word-address width (64-bit words)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear: all state to reset values, buffers discarded, FSM to IDLE
- start  in  1  one-cycle pulse; begins a frame; ignored unless IDLE
- stride2_en  in  1  sampled at start; 1 = active size OUT_W/2 x OUT_H/2, 0 = OUT_W x OUT_H
- base_addr  in  ADDR_W  sampled at start; word address of pixel (0,0)
- data_in  in  8x8  lane i = pixel row tr*8+i of current column
- data_vld_in  in  1  beat valid
- data_rdy_out  out  1  beat accepted when data_vld_in && data_rdy_out
- mem_wdata  out  64  row word; byte k at [8k+7:8k] = column tc*8+k
- mem_addr  out  ADDR_W  word address
- mem_we  out  1  write request
- mem_gnt  in  1  write accepted when mem_we && mem_gnt
- busy  out  1  high in ACTIVE and FLUSH
- done  out  1  one-cycle pulse after last word granted

## Operation
- Active size W x H from stride2_en; pitch P = W/8 words; tiles per row TW = W/8; tile rows TH = H/8.
- Beat stream order: tile row tr = 0..TH-1; within it column c = 0..W-1; tile tc = c/8, beat k = c%8.
- Fill: beat k writes lane i into byte k of row i of the fill buffer. After 8 beats the buffer is marked full and fill switches to the other buffer.
- Drain: the oldest full buffer emits rows i = 0..7 in order, at mem_addr = base_addr + (tr*8+i)*P + tc, modulo 2^ADDR_W. Addresses are generated with accumulators, no multiplier. The buffer is freed after row 7 is granted.
- FSM:
  - IDLE -> ACTIVE on start.
  - ACTIVE -> FLUSH when beat W*TH (the last beat) is accepted.
  - FLUSH -> DONE when the last word is granted.
  - DONE -> IDLE after 1 cycle, with done=1.
- data_rdy_out = (state==ACTIVE) && fill buffer empty.
- Beats presented outside ACTIVE are not accepted.
- Simultaneous events:
  - A buffer freed in the same cycle as the other becomes full: the fill side may take the freed buffer the next cycle.
  - clr has priority over start and over all handshakes.
- rst_n or clr mid-frame abandons the frame; no done pulse is produced.

## Timing
- Reset values: data_rdy_out 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0. All outputs are registered.
- busy rises the cycle after start.
- data_rdy_out rises the cycle after start.
- First mem_we: the cycle after the 8th beat of a tile is accepted.
- While mem_we && !mem_gnt, mem_wdata and mem_addr are held stable. After a grant, the next row is presented the following cycle, so a continuous grant gives 1 word/cycle.
- With both buffers free and mem_gnt tied high, beats stream at 1/cycle with no bubbles.
- done pulses the cycle after the final grant; busy falls in the same cycle.

## Configuration
- COL2IMG8_PINGPONG_EN defined: two tile buffers, operating as described above.
- COL2IMG8_PINGPONG_EN undefined: single buffer. data_rdy_out is low from the 8th accepted beat until row 7 of that tile is granted. Throughput is at most 8 beats per 17 cycles with mem_gnt=1. Addresses and data are identical in both builds.

## Test plan
- Stride 1, base 0x0100, OUT_W=32, OUT_H=16, beat value lane i of column c = (r<<4)|c[3:0], mem_gnt=1 -> 64 writes. Word at 0x0100+r*4+tc has byte k = (r<<4)|((tc*8+k)&15); done pulses exactly once.
- Same frame with stride2_en=1, base 0x0200 -> P=2; 16 beats, 16 writes covering 0x0200..0x020F; mem_addr = 0x0200 + r*2 + tc for row r, tile tc.
- mem_gnt low for 5 cycles on row 3 of tile 0 -> mem_wdata and mem_addr are unchanged across the stall; the fill side keeps accepting into buffer 1, then data_rdy_out drops when buffer 1 is full.
- base_addr 0xFFF8, stride 1 -> row 2 of tile 0 writes to 0x0000, i.e. wrap-around modulo 2^16.
- clr asserted after 12 beats -> next cycle all outputs are at reset values and state is IDLE, with no done pulse. A subsequent start runs a clean frame.
- Build without COL2IMG8_PINGPONG_EN, mem_gnt=1 -> data_rdy_out is low for exactly 9 cycles after each 8th beat; the data sequence matches test 1.

Source files
------------

// File: rtl/col2img8_if.sv
// col2img8 beat-input and memory-write bundle.
// master drives beats and grants; slave is the transposer.
interface col2img8_if #(
  parameter int ADDR_W = 16
) ();
  logic [63:0]       data_in;
  logic              data_vld_in;
  logic              data_rdy_out;
  logic [63:0]       mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_gnt;

  modport master (
    output data_in, data_vld_in, mem_gnt,
    input  data_rdy_out, mem_wdata, mem_addr, mem_we
  );

  modport slave (
    input  data_in, data_vld_in, mem_gnt,
    output data_rdy_out, mem_wdata, mem_addr, mem_we
  );
endinterface

// File: rtl/col2img8.sv
// col2img8: 8x8 column-to-row tile transposer and write-back.
// COL2IMG8_PINGPONG_EN selects two tile buffers; default is one.
module col2img8 #(
  parameter int OUT_W  = 32,
  parameter int OUT_H  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              start,
  input  logic              stride2_en,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  col2img8_if.slave         bus
);
  typedef enum logic [1:0] {
    IDLE, ACTIVE, FLUSH, DONE
  } state_t;

  localparam int CW = $clog2((OUT_W / 8) * (OUT_H / 8)) + 1;
  localparam logic [CW-1:0] NT1M =
    CW'((OUT_W / 8) * (OUT_H / 8) - 1);
  localparam logic [CW-1:0] NT2M =
    CW'((OUT_W / 16) * (OUT_H / 16) - 1);
  localparam logic [CW-1:0] TW1M = CW'(OUT_W / 8 - 1);
  localparam logic [CW-1:0] TW2M = CW'(OUT_W / 16 - 1);
  localparam logic [ADDR_W-1:0] W1 = ADDR_W'(OUT_W);
  localparam logic [ADDR_W-1:0] W2 = ADDR_W'(OUT_W / 2);
  localparam logic [ADDR_W-1:0] P1 = ADDR_W'(OUT_W / 8);
  localparam logic [ADDR_W-1:0] P2 = ADDR_W'(OUT_W / 16);

  state_t            state_q, state_d;
  logic              stride_q, stride_d;
  logic              fsel_q, fsel_d;
  logic              dsel_q, dsel_d;
  logic [1:0]        full_q, full_d;
  logic [2:0]        k_q, k_d;
  logic [2:0]        row_q, row_d;
  logic [CW-1:0]     ftile_q, ftile_d;
  logic [CW-1:0]     dtile_q, dtile_d;
  logic [CW-1:0]     tc_q, tc_d;
  logic [ADDR_W-1:0] rbase_q, rbase_d;
  logic [ADDR_W-1:0] taddr_q, taddr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [63:0]       buf_q [2][8];
  logic [63:0]       buf_d [2][8];

  logic              acc, gnt, fin;
  logic [2:0]        row_nx;
  logic [CW-1:0]     ntm, twm;
  logic [ADDR_W-1:0] wpix, pitch;

  assign acc = bus.data_vld_in && rdy_q;
  assign gnt = we_q && bus.mem_gnt;

  // Next-state: FSM, tile fill, row drain and address walk.
  always_comb begin
    state_d  = state_q;
    stride_d = stride_q;
    fsel_d   = fsel_q;
    dsel_d   = dsel_q;
    full_d   = full_q;
    k_d      = k_q;
    row_d    = row_q;
    ftile_d  = ftile_q;
    dtile_d  = dtile_q;
    tc_d     = tc_q;
    rbase_d  = rbase_q;
    taddr_d  = taddr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    buf_d    = buf_q;
    fin      = 1'b0;
    ntm      = stride_q ? NT2M : NT1M;
    twm      = stride_q ? TW2M : TW1M;
    wpix     = stride_q ? W2 : W1;
    pitch    = stride_q ? P2 : P1;
    row_nx   = row_q + 3'd1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ACTIVE;
          stride_d = stride2_en;
          fsel_d   = 1'b0;
          dsel_d   = 1'b0;
          full_d   = '0;
          k_d      = '0;
          row_d    = '0;
          ftile_d  = '0;
          dtile_d  = '0;
          tc_d     = '0;
          rbase_d  = base_addr;
          taddr_d  = base_addr;
        end
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase

    if (acc) begin
      for (int i = 0; i < 8; i++) begin
        buf_d[fsel_q][i][8*k_q +: 8] =
          bus.data_in[8*i +: 8];
      end
      k_d = k_q + 3'd1;
      if (k_q == 3'd7) begin
        full_d[fsel_q] = 1'b1;
`ifdef COL2IMG8_PINGPONG_EN
        fsel_d = ~fsel_q;
`endif
        ftile_d = ftile_q + CW'(1);
        if (ftile_q == ntm) state_d = FLUSH;
      end
    end

    if (gnt) begin
      if (row_q == 3'd7) begin
        full_d[dsel_q] = 1'b0;
`ifdef COL2IMG8_PINGPONG_EN
        dsel_d = ~dsel_q;
`endif
        row_d   = '0;
        we_d    = 1'b0;
        dtile_d = dtile_q + CW'(1);
        if (tc_q == twm) begin
          tc_d    = '0;
          rbase_d = rbase_q + wpix;
          taddr_d = rbase_q + wpix;
        end else begin
          tc_d    = tc_q + CW'(1);
          taddr_d = taddr_q + ADDR_W'(1);
        end
        if (dtile_q == ntm) begin
          fin     = 1'b1;
          state_d = DONE;
        end
      end else begin
        row_d   = row_nx;
        addr_d  = addr_q + pitch;
        wdata_d = buf_q[dsel_q][row_nx];
      end
    end

    // Row 0 reads buf_d so a tile completing now is forwarded.
    if ((!we_q || (gnt && row_q == 3'd7)) &&
        full_d[dsel_d] && !fin) begin
      we_d    = 1'b1;
      addr_d  = taddr_d;
      wdata_d = buf_d[dsel_d][0];
    end

    if (clr) begin
      state_d  = IDLE;
      stride_d = 1'b0;
      fsel_d   = 1'b0;
      dsel_d   = 1'b0;
      full_d   = '0;
      k_d      = '0;
      row_d    = '0;
      ftile_d  = '0;
      dtile_d  = '0;
      tc_d     = '0;
      rbase_d  = '0;
      taddr_d  = '0;
      addr_d   = '0;
      wdata_d  = '0;
      we_d     = 1'b0;
    end

    busy_d = (state_d == ACTIVE) || (state_d == FLUSH);
    done_d = (state_d == DONE);
    rdy_d  = (state_d == ACTIVE) && !full_d[fsel_d];
`ifndef COL2IMG8_PINGPONG_EN
    // Single buffer reopens one cycle after its last row.
    if (gnt && row_q == 3'd7) rdy_d = 1'b0;
`endif
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      stride_q <= 1'b0;
      fsel_q   <= 1'b0;
      dsel_q   <= 1'b0;
      full_q   <= '0;
      k_q      <= '0;
      row_q    <= '0;
      ftile_q  <= '0;
      dtile_q  <= '0;
      tc_q     <= '0;
      rbase_q  <= '0;
      taddr_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stride_q <= stride_d;
      fsel_q   <= fsel_d;
      dsel_q   <= dsel_d;
      full_q   <= full_d;
      k_q      <= k_d;
      row_q    <= row_d;
      ftile_q  <= ftile_d;
      dtile_q  <= dtile_d;
      tc_q     <= tc_d;
      rbase_q  <= rbase_d;
      taddr_q  <= taddr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Tile storage; validity is tracked by full_q.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign bus.data_rdy_out = rdy_q;
  assign bus.mem_we       = we_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign busy             = busy_q;
  assign done             = done_q;
endmodule

// File: tb/tb_col2img8.sv
// tb_col2img8: image-level reference model for col2img8.
// Expected writes come from transposing the stimulus image.
module tb_col2img8;
`ifdef COL2IMG8_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        start;
  logic        stride2_en;
  logic [15:0] base_addr;
  logic        busy;
  logic        done;

  col2img8_if #(.ADDR_W(16)) bif ();

  col2img8 #(
    .OUT_W (32),
    .OUT_H (16),
    .ADDR_W(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .start     (start),
    .stride2_en(stride2_en),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .bus       (bif.slave)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  logic [7:0]  img [16][32];
  logic [15:0] got_a [$];
  logic [63:0] got_d [$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic fill_pattern();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 32; c++)
        img[r][c] = 8'((r << 4) | (c & 15));
  endtask

  task automatic fill_random();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 32; c++)
        img[r][c] = 8'($urandom);
  endtask

  // Caller is positioned just after a rising edge.
  task automatic run_frame(input bit s2,
                           input logic [15:0] base,
                           input bit vr,
                           input bit gr,
                           input bit stl,
                           input int clr_at);
    int w, h, p, nb, bi, stall_left, lowcnt;
    int acc_stall, done_cnt;
    bit meas, chkwe, fin;
    logic [63:0] beats [$];
    logic [15:0] ea [$];
    logic [63:0] ed [$];
    logic [63:0] v;
    logic [15:0] snap_a;
    logic [63:0] snap_d;

    w = s2 ? 16 : 32;
    h = s2 ? 8 : 16;
    p = w / 8;
    for (int tr = 0; tr < h / 8; tr++)
      for (int c = 0; c < w; c++) begin
        v = '0;
        for (int i = 0; i < 8; i++)
          v[8*i +: 8] = img[tr*8+i][c];
        beats.push_back(v);
      end
    for (int tr = 0; tr < h / 8; tr++)
      for (int tc = 0; tc < w / 8; tc++)
        for (int i = 0; i < 8; i++) begin
          ea.push_back(16'(int'(base) + (tr*8+i)*p + tc));
          v = '0;
          for (int k = 0; k < 8; k++)
            v[8*k +: 8] = img[tr*8+i][tc*8+k];
          ed.push_back(v);
        end
    nb = beats.size();
    got_a = {};
    got_d = {};
    bi = 0;
    stall_left = stl ? 5 : 0;
    lowcnt = 0;
    acc_stall = 0;
    done_cnt = 0;
    meas = 0;
    chkwe = 0;
    fin = 0;
    snap_a = '0;
    snap_d = '0;

    start = 1'b1;
    stride2_en = s2;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    stride2_en = ~s2;
    base_addr = ~base;

    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      bif.data_vld_in = (bi < nb) &&
                        (!vr || $urandom_range(3) != 0);
      bif.data_in = (bi < nb) ? beats[bi] : 64'h0;
      bif.mem_gnt = !gr || $urandom_range(2) != 0;
      if (stl && got_a.size() == 3 && stall_left > 0)
        bif.mem_gnt = 1'b0;
      @(negedge clk);
      if (cyc == 0) begin
        chk("busy_rise", busy, 1);
        chk("rdy_rise", bif.data_rdy_out, 1);
      end
      if (meas) begin
        if (!bif.data_rdy_out) lowcnt++;
        else begin
          if (!gr && !stl)
            chk($sformatf("rdy_low_b%0d", bi), lowcnt,
                PP ? 0 : 9);
          meas = 0;
        end
      end
      if (chkwe) begin
        chk("first_we", bif.mem_we, 1);
        chkwe = 0;
      end
      if (stl && bif.mem_we && !bif.mem_gnt &&
          got_a.size() == 3 && stall_left > 0) begin
        if (stall_left == 5) begin
          snap_a = bif.mem_addr;
          snap_d = bif.mem_wdata;
          chk("stall_a_row3", snap_a, ea[3]);
          chk("stall_d_row3", snap_d, ed[3]);
        end else begin
          chk("stall_a_hold", bif.mem_addr, snap_a);
          chk("stall_d_hold", bif.mem_wdata, snap_d);
        end
        if (bif.data_vld_in && bif.data_rdy_out)
          acc_stall++;
        stall_left--;
      end
      if (bif.data_vld_in && bif.data_rdy_out) begin
        if (bi == 7) chkwe = 1;
        if (bi % 8 == 7 && bi + 1 < nb) begin
          meas = 1;
          lowcnt = 0;
        end
        bi++;
      end
      if (bif.mem_we && bif.mem_gnt) begin
        got_a.push_back(bif.mem_addr);
        got_d.push_back(bif.mem_wdata);
      end
      if (done) begin
        done_cnt++;
        chk("busy_at_done", busy, 0);
        fin = 1;
      end
      if (clr_at > 0 && bi == clr_at) break;
      @(posedge clk); #1;
    end

    if (clr_at > 0) begin
      chk("clr_reached", bi, clr_at);
      @(posedge clk); #1;
      clr = 1'b1;
      bif.data_vld_in = 1'b0;
      bif.mem_gnt = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      bif.data_vld_in = 1'b1;
      @(negedge clk);
      chk("clr_rdy", bif.data_rdy_out, 0);
      chk("clr_we", bif.mem_we, 0);
      chk("clr_addr", bif.mem_addr, 0);
      chk("clr_wdata", bif.mem_wdata, 0);
      chk("clr_busy", busy, 0);
      chk("clr_done", done, 0);
      done_cnt = 0;
      lowcnt = 0;
      repeat (30) begin
        @(negedge clk);
        if (done) done_cnt++;
        if (bif.data_rdy_out || bif.mem_we) lowcnt++;
      end
      chk("clr_no_done", done_cnt, 0);
      chk("clr_quiet", lowcnt, 0);
      chk("clr_idle_busy", busy, 0);
      bif.data_vld_in = 1'b0;
      @(posedge clk); #1;
      return;
    end

    chk("frame_finished", fin, 1);
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("busy_idle", busy, 0);
    chk("rdy_idle", bif.data_rdy_out, 0);
    chk("done_once", done_cnt, 1);
    if (stl) chk("stall_fill_other", acc_stall > 0, PP);
    chk("n_writes", got_a.size(), ea.size());
    for (int i = 0; i < ea.size() && i < got_a.size(); i++) begin
      chk($sformatf("addr_w%0d", i), got_a[i], ea[i]);
      chk($sformatf("data_w%0d", i), got_d[i], ed[i]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    start = 1'b0;
    stride2_en = 1'b0;
    base_addr = '0;
    bif.data_in = '0;
    bif.data_vld_in = 1'b0;
    bif.mem_gnt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", bif.data_rdy_out, 0);
    chk("rst_we", bif.mem_we, 0);
    chk("rst_addr", bif.mem_addr, 0);
    chk("rst_wdata", bif.mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    fill_pattern();
    run_frame(1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 0);
    run_frame(1'b1, 16'h0200, 1'b0, 1'b0, 1'b0, 0);

    fill_random();
    run_frame(1'b0, 16'($urandom), 1'b0, 1'b0, 1'b1, 0);

    fill_random();
    run_frame(1'b0, 16'hFFF8, 1'b0, 1'b0, 1'b0, 0);
    if (got_a.size() > 2) chk("wrap_row2", got_a[2], 16'h0000);

    fill_random();
    run_frame(1'b0, 16'h0040, 1'b1, 1'b0, 1'b0, 12);
    run_frame(1'b0, 16'h0040, 1'b1, 1'b0, 1'b0, 0);

    fill_random();
    run_frame(1'($urandom_range(1)), 16'($urandom),
              1'b1, 1'b1, 1'b0, 0);
    fill_random();
    run_frame(1'b1, 16'($urandom), 1'b0, 1'b1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end
endmodule
